stickit_ctrl: RTL



---
 rtl/stickit_pkg.sv | 17 +
 rtl/stickit_rr_arb.sv | 24 ++
 rtl/stickit_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/stickit_pkg.sv
// Shared types and constants for the StickIt! display-sharing controller.
package stickit_pkg;
  typedef enum logic {IDLE, OWN} state_t;

  localparam int DIGITS  = 8;
  localparam int DIGIT_W = 3;
  localparam int VALUE_W = 32;
  localparam int IDX_W   = 3;  // requester index width, covers up to 8 requesters

  function automatic logic [IDX_W-1:0] oh2idx(input logic [7:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < 8; k++)
      if (oh[k]) idx |= IDX_W'(k);
    return idx;
  endfunction
endpackage

// File: rtl/stickit_rr_arb.sv
// Combinational round-robin picker: first set request at or above start, wrapping.
import stickit_pkg::*;

module stickit_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic             vld
);
  logic [N-1:0] mask, hi, sel;

  always_comb begin
    mask = '0;
    for (int k = 0; k < N; k++)
      mask[k] = (IDX_W'(k) >= start);
    hi  = req & mask;
    // no request at/above start means the search wraps to the bottom
    sel = (|hi) ? hi : req;
    gnt = sel & (-sel);
    vld = |req;
  end
endmodule

// File: rtl/stickit_ctrl.sv
// Display-sharing controller: scan divider, digit counter and frame-granular RR ownership.
// Build option: STICKIT_CTRL_IDLE_HOLD_EN keeps the last owner's value on VALUE_OUT in IDLE.
import stickit_pkg::*;

module stickit_ctrl #(
  parameter int N_REQ       = 4,
  parameter int CLK_DIV     = 200,
  parameter int HOLD_FRAMES = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [VALUE_W*N_REQ-1:0] REQ_VALUE,
  output logic [N_REQ-1:0]         GNT,
  output logic                     BUSY,
  output logic [VALUE_W-1:0]       VALUE_OUT,
  output logic                     SCAN_EN,
  output logic [DIGIT_W-1:0]       DIGIT
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int FC_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_PRE    = DIV_W'(CLK_DIV - 2);
  localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0]   PTR_LAST   = IDX_W'(N_REQ - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGITS - 1);

  logic [DIV_W-1:0]   div_cnt;
  state_t             state, state_n;
  logic [FC_W-1:0]    frame_cnt, fcnt_n;
  logic [IDX_W-1:0]   ptr, ptr_n, new_idx, new_ptr;
  logic [N_REQ-1:0]   arb_req, arb_gnt, gnt_n;
  logic               arb_vld, frame_end, own_req, take;
  logic [VALUE_W-1:0] new_val, own_val, val_n;

  // The owner is masked out, so one picker serves both the IDLE pick and the handover.
  // While owning, ptr always equals owner+1 mod N_REQ, the handover start index.
  assign arb_req = REQ & ~GNT;

  stickit_rr_arb #(.N(N_REQ)) u_arb (
    .req   (arb_req),
    .start (ptr),
    .gnt   (arb_gnt),
    .vld   (arb_vld)
  );

  assign frame_end = SCAN_EN && (DIGIT == DIGIT_LAST);
  assign own_req   = |(REQ & GNT);
  assign new_idx   = oh2idx(8'(arb_gnt));
  assign new_ptr   = (new_idx == PTR_LAST) ? '0 : new_idx + 1'b1;

  always_comb begin
    new_val = '0;
    own_val = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_gnt[k]) new_val |= REQ_VALUE[VALUE_W*k +: VALUE_W];
      if (GNT[k])     own_val |= REQ_VALUE[VALUE_W*k +: VALUE_W];
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = GNT;
    val_n   = VALUE_OUT;
    fcnt_n  = frame_cnt;
    ptr_n   = ptr;
    take    = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: take = arb_vld;
        OWN: begin
          if (!own_req) begin
            if (arb_vld) take = 1'b1;
            else begin
              state_n = IDLE;
              gnt_n   = '0;
              fcnt_n  = '0;
`ifdef STICKIT_CTRL_IDLE_HOLD_EN
              val_n   = VALUE_OUT;
`else
              val_n   = '0;
`endif
            end
          end else if (frame_cnt == FC_LAST && arb_vld) begin
            take = 1'b1;
          end else begin
            val_n = own_val;
            if (frame_cnt != FC_LAST) fcnt_n = frame_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (take) begin
      state_n = OWN;
      gnt_n   = arb_gnt;
      val_n   = new_val;
      fcnt_n  = '0;
      ptr_n   = new_ptr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt   <= '0;
      SCAN_EN   <= 1'b0;
      DIGIT     <= '0;
      state     <= IDLE;
      frame_cnt <= '0;
      ptr       <= '0;
      GNT       <= '0;
      BUSY      <= 1'b0;
      VALUE_OUT <= '0;
    end else begin
      div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      // registered strobe lands in the cycle where div_cnt reads CLK_DIV-1
      SCAN_EN   <= (div_cnt == DIV_PRE);
      if (SCAN_EN) DIGIT <= DIGIT + 1'b1;
      state     <= state_n;
      frame_cnt <= fcnt_n;
      ptr       <= ptr_n;
      GNT       <= gnt_n;
      BUSY      <= |gnt_n;
      VALUE_OUT <= val_n;
    end
  end
endmodule
